// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: FSM state encoding,
// load/store size codes and the size-to-byte-count helper.
package mem_ctrl_pkg;

    // Default I-cache line size in bytes
    localparam int unsigned DEFAULT_LINE_BYTES = 64;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_IF_READ  = 3'd1,
        ST_LS_READ  = 3'd2,
        ST_LS_WRITE = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    // Load/store access size codes
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Number of RAM bytes touched by an access; code 3 behaves as a word
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Memory controller: serializes I-cache line refills and load/store
// accesses onto a single byte-wide RAM port. Load/store wins over refill,
// one access is outstanding at a time, and every access ends with a
// one-cycle DONE state so the client can drop its request level.
module mem_ctrl #(
    parameter int unsigned LINE_BYTES = mem_ctrl_pkg::DEFAULT_LINE_BYTES,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic [ADDR_W-1:0]       missing_PC,
    input  logic                    missing_config,
    output logic [8*LINE_BYTES-1:0] return_row,
    output logic                    return_config,
    input  logic                    lsb_req,
    input  logic                    lsb_we,
    input  logic [1:0]              lsb_size,
    input  logic [ADDR_W-1:0]       lsb_addr,
    input  logic [31:0]             lsb_wdata,
    output logic [31:0]             lsb_rdata,
    output logic                    lsb_done,
    input  logic                    rollback_config,
    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [ADDR_W-1:0]       mem_a,
    output logic                    mem_wr
);
    import mem_ctrl_pkg::*;

    localparam int unsigned IDX_W = $clog2(LINE_BYTES);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam int unsigned ROW_W = 8 * LINE_BYTES;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [CNT_W-1:0]   nbytes_q, nbytes_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [ADDR_W-1:0]  mem_a_q, mem_a_d;
    logic [7:0]         mem_dout_q, mem_dout_d;
    logic               mem_wr_q, mem_wr_d;
    logic [ROW_W-1:0]   return_row_q, return_row_d;
    logic               return_config_q, return_config_d;
    logic [31:0]        lsb_rdata_q, lsb_rdata_d;
    logic               lsb_done_q, lsb_done_d;

    // Arbitration: a rollback only suppresses a load, never a store
    logic take_st, take_ld, take_if;
    assign take_st = lsb_req & lsb_we;
    assign take_ld = lsb_req & ~lsb_we & ~rollback_config;
    assign take_if = missing_config & ~take_st & ~take_ld;

    // Line base: offset bits inside the line are dropped
    logic [ADDR_W-1:0] line_base;
    logic              unused_pc_lo;
    assign line_base    = {missing_PC[ADDR_W-1:IDX_W], {IDX_W{1'b0}}};
    assign unused_pc_lo = ^missing_PC[IDX_W-1:0];

    // Counter-derived indices: cnt_q-1 is the byte arriving on mem_din,
    // cnt_q+1 is the next address to issue
    logic [CNT_W-1:0] cnt_inc, cnt_dec;
    logic [IDX_W-1:0] row_idx;
    logic [1:0]       rd_idx, wr_idx;
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign cnt_dec = cnt_q - CNT_W'(1);
    assign row_idx = cnt_dec[IDX_W-1:0];
    assign rd_idx  = cnt_dec[1:0];
    assign wr_idx  = cnt_inc[1:0];

    // State register: async reset, frozen while rdy is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else if (rdy) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (take_st)      state_d = ST_LS_WRITE;
                else if (take_ld) state_d = ST_LS_READ;
                else if (take_if) state_d = ST_IF_READ;
            end
            ST_IF_READ: begin
                if (cnt_q == nbytes_q) state_d = ST_DONE;
            end
            ST_LS_READ: begin
                if (rollback_config)        state_d = ST_IDLE;
                else if (cnt_q == nbytes_q) state_d = ST_DONE;
            end
            ST_LS_WRITE: begin
                if (cnt_inc >= nbytes_q) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values: address issue, byte capture, pulses
    always_comb begin
        cnt_d           = cnt_q;
        base_d          = base_q;
        nbytes_d        = nbytes_q;
        wdata_d         = wdata_q;
        mem_a_d         = mem_a_q;
        mem_dout_d      = mem_dout_q;
        mem_wr_d        = 1'b0;
        return_row_d    = return_row_q;
        return_config_d = 1'b0;
        lsb_rdata_d     = lsb_rdata_q;
        lsb_done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (take_st) begin
                    base_d     = lsb_addr;
                    nbytes_d   = CNT_W'(size_bytes(lsb_size));
                    wdata_d    = lsb_wdata;
                    mem_a_d    = lsb_addr;
                    mem_dout_d = lsb_wdata[7:0];
                    mem_wr_d   = 1'b1;
                end else if (take_ld) begin
                    base_d      = lsb_addr;
                    nbytes_d    = CNT_W'(size_bytes(lsb_size));
                    mem_a_d     = lsb_addr;
                    lsb_rdata_d = '0;
                end else if (take_if) begin
                    base_d   = line_base;
                    nbytes_d = CNT_W'(LINE_BYTES);
                    mem_a_d  = line_base;
                end
            end
            ST_IF_READ: begin
                cnt_d = cnt_inc;
                if (cnt_inc < nbytes_q) mem_a_d = base_q + ADDR_W'(cnt_inc);
                if (cnt_q != '0) return_row_d[{row_idx, 3'b000} +: 8] = mem_din;
                if (cnt_q == nbytes_q) return_config_d = 1'b1;
            end
            ST_LS_READ: begin
                if (rollback_config) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc < nbytes_q) mem_a_d = base_q + ADDR_W'(cnt_inc);
                    if (cnt_q != '0) lsb_rdata_d[{rd_idx, 3'b000} +: 8] = mem_din;
                    if (cnt_q == nbytes_q) lsb_done_d = 1'b1;
                end
            end
            ST_LS_WRITE: begin
                cnt_d = cnt_inc;
                if (cnt_inc < nbytes_q) begin
                    mem_a_d    = base_q + ADDR_W'(cnt_inc);
                    mem_dout_d = wdata_q[{wr_idx, 3'b000} +: 8];
                    mem_wr_d   = 1'b1;
                end else begin
                    lsb_done_d = 1'b1;
                end
            end
            ST_DONE: begin
                cnt_d = '0;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Datapath and output registers: async reset, frozen while rdy is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q          <= '0;
            nbytes_q        <= '0;
            wdata_q         <= '0;
            mem_a_q         <= '0;
            mem_dout_q      <= '0;
            mem_wr_q        <= 1'b0;
            return_row_q    <= '0;
            return_config_q <= 1'b0;
            lsb_rdata_q     <= '0;
            lsb_done_q      <= 1'b0;
        end else if (rdy) begin
            base_q          <= base_d;
            nbytes_q        <= nbytes_d;
            wdata_q         <= wdata_d;
            mem_a_q         <= mem_a_d;
            mem_dout_q      <= mem_dout_d;
            mem_wr_q        <= mem_wr_d;
            return_row_q    <= return_row_d;
            return_config_q <= return_config_d;
            lsb_rdata_q     <= lsb_rdata_d;
            lsb_done_q      <= lsb_done_d;
        end
    end

    assign mem_a         = mem_a_q;
    assign mem_dout      = mem_dout_q;
    assign mem_wr        = mem_wr_q & rdy;
    assign return_row    = return_row_q;
    assign return_config = return_config_q;
    assign lsb_rdata     = lsb_rdata_q;
    assign lsb_done      = lsb_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed testbench for mem_ctrl with a byte-wide synchronous RAM model.
// The RAM port shares the global rdy enable, so a stalled controller sees
// the same read data when it resumes.
module tb_mem_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         rdy;
    logic [31:0]  missing_PC;
    logic         missing_config;
    logic [511:0] return_row;
    logic         return_config;
    logic         lsb_req;
    logic         lsb_we;
    logic [1:0]   lsb_size;
    logic [31:0]  lsb_addr;
    logic [31:0]  lsb_wdata;
    logic [31:0]  lsb_rdata;
    logic         lsb_done;
    logic         rollback_config;
    logic [7:0]   mem_din;
    logic [7:0]   mem_dout;
    logic [31:0]  mem_a;
    logic         mem_wr;

    logic [7:0]   ram [0:65535];
    int           wr_cnt = 0;
    logic [31:0]  wr_last_a = 32'h0;

    int total = 0;
    int bad   = 0;

    mem_ctrl #(.LINE_BYTES(64), .ADDR_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .missing_PC      (missing_PC),
        .missing_config  (missing_config),
        .return_row      (return_row),
        .return_config   (return_config),
        .lsb_req         (lsb_req),
        .lsb_we          (lsb_we),
        .lsb_size        (lsb_size),
        .lsb_addr        (lsb_addr),
        .lsb_wdata       (lsb_wdata),
        .lsb_rdata       (lsb_rdata),
        .lsb_done        (lsb_done),
        .rollback_config (rollback_config),
        .mem_din         (mem_din),
        .mem_dout        (mem_dout),
        .mem_a           (mem_a),
        .mem_wr          (mem_wr)
    );

    always #5 clk = ~clk;

    // RAM: read-first, one-cycle read latency, enabled by rdy
    always @(posedge clk) begin
        if (rdy) begin
            if (mem_wr) begin
                ram[mem_a[15:0]] <= mem_dout;
                wr_cnt           <= wr_cnt + 1;
                wr_last_a        <= mem_a;
            end
            mem_din <= ram[mem_a[15:0]];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic test_reset();
        @(negedge clk);
        total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL reset_mem_wr got=%b want=0", mem_wr); end
        total++; if (mem_a !== 32'h0) begin bad++; $display("FAIL reset_mem_a got=%h want=0", mem_a); end
        total++; if (mem_dout !== 8'h0) begin bad++; $display("FAIL reset_mem_dout got=%h want=0", mem_dout); end
        total++; if ({return_config, lsb_done} !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%b want=00", {return_config, lsb_done}); end
        total++; if (lsb_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", lsb_rdata); end
        total++; if (return_row !== 512'h0) begin bad++; $display("FAIL reset_row got nonzero want=0"); end
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (mem_a !== 32'h0 || mem_wr !== 1'b0) begin bad++; $display("FAIL reset_idle mem_a=%h mem_wr=%b want 0/0", mem_a, mem_wr); end
    endtask

    task automatic test_refill();
        logic [511:0] exp_row;
        int addr_bad;
        int pulse_bad;
        addr_bad = 0; pulse_bad = 0;
        for (int k = 0; k < 64; k++) exp_row[8*k +: 8] = 8'(k);
        @(posedge clk); #1;
        missing_PC = 32'h0000_1004; missing_config = 1'b1;
        for (int j = 0; j <= 67; j++) begin
            @(posedge clk);
            if (j == 66) begin #1; missing_config = 1'b0; end
            @(negedge clk);
            if (j < 64 && mem_a !== 32'h1000 + 32'(j)) addr_bad++;
            if (mem_wr !== 1'b0) addr_bad++;
            if (return_config !== (j == 65)) pulse_bad++;
            if (j == 65) begin
                total++;
                if (return_row !== exp_row) begin bad++; $display("FAIL refill_row got=%h want=%h", return_row, exp_row); end
            end
        end
        total++; if (addr_bad != 0) begin bad++; $display("FAIL refill_addr wrong cycles=%0d want 0", addr_bad); end
        total++; if (pulse_bad != 0) begin bad++; $display("FAIL refill_pulse wrong cycles=%0d want 0", pulse_bad); end
    endtask

    task automatic test_load();
        int n;
        logic [31:0] addr, exp_data;
        int done_bad, a_bad;
        for (int v = 0; v < 2; v++) begin
            n        = (v == 0) ? 4 : 2;
            addr     = (v == 0) ? 32'h2000 : 32'h2002;
            exp_data = (v == 0) ? 32'h1234_5678 : 32'h0000_1234;
            done_bad = 0; a_bad = 0;
            @(posedge clk); #1;
            lsb_addr = addr; lsb_size = (v == 0) ? 2'd2 : 2'd1; lsb_we = 1'b0; lsb_req = 1'b1;
            for (int j = 0; j <= n + 2; j++) begin
                @(posedge clk);
                if (j == n + 2) begin #1; lsb_req = 1'b0; end
                @(negedge clk);
                if (lsb_done !== (j == n + 1)) done_bad++;
                if (mem_wr !== 1'b0) a_bad++;
                if (j < n && mem_a !== addr + 32'(j)) a_bad++;
                if (j == n + 1) begin
                    total++;
                    if (lsb_rdata !== exp_data) begin bad++; $display("FAIL load_data%0d got=%h want=%h", v, lsb_rdata, exp_data); end
                end
            end
            total++; if (done_bad != 0) begin bad++; $display("FAIL load_done%0d wrong cycles=%0d want 0", v, done_bad); end
            total++; if (a_bad != 0) begin bad++; $display("FAIL load_addr%0d wrong cycles=%0d want 0", v, a_bad); end
        end
    endtask

    task automatic test_store();
        int wr0;
        int st_bad;
        st_bad = 0;
        wr0 = wr_cnt;
        @(posedge clk); #1;
        lsb_addr = 32'h3001; lsb_size = 2'd0; lsb_we = 1'b1; lsb_wdata = 32'hDEAD_BEAB; lsb_req = 1'b1;
        for (int j = 0; j <= 2; j++) begin
            @(posedge clk);
            if (j == 2) begin #1; lsb_req = 1'b0; end
            @(negedge clk);
            if (mem_wr !== (j == 0)) st_bad++;
            if (lsb_done !== (j == 1)) st_bad++;
            if (j == 0 && (mem_a !== 32'h3001 || mem_dout !== 8'hAB)) st_bad++;
        end
        total++; if (st_bad != 0) begin bad++; $display("FAIL store_byte_cycles wrong=%0d want 0", st_bad); end
        total++; if (wr_cnt - wr0 != 1) begin bad++; $display("FAIL store_byte_count got=%0d want=1", wr_cnt - wr0); end
        total++; if ({ram[16'h3000], ram[16'h3001], ram[16'h3002]} !== 24'h11AB33) begin
            bad++; $display("FAIL store_byte_ram got=%h want=11ab33", {ram[16'h3000], ram[16'h3001], ram[16'h3002]});
        end
    endtask

    task automatic test_back_to_back();
        logic [511:0] exp_row;
        int got, st_bad, pulse_bad;
        got = -1; st_bad = 0; pulse_bad = 0;
        for (int k = 0; k < 64; k++) exp_row[8*k +: 8] = 8'(k);
        @(posedge clk); #1;
        missing_PC = 32'h0000_1010; missing_config = 1'b1;
        lsb_addr = 32'h3010; lsb_size = 2'd1; lsb_we = 1'b1; lsb_wdata = 32'h1234_BEEF; lsb_req = 1'b1;
        for (int j = 0; j <= 90; j++) begin
            @(posedge clk);
            if (j == 3) begin #1; lsb_req = 1'b0; end
            if (got >= 0 && j == got + 1) begin #1; missing_config = 1'b0; end
            @(negedge clk);
            if (j < 2 && (mem_wr !== 1'b1 || mem_a !== 32'h3010 + 32'(j) || mem_dout !== ((j == 0) ? 8'hEF : 8'hBE))) st_bad++;
            if (j >= 2 && mem_wr !== 1'b0) st_bad++;
            if (lsb_done !== (j == 2)) st_bad++;
            if (j == 3) begin
                total++;
                if (mem_a !== 32'h3011) begin bad++; $display("FAIL b2b_done_ignores got mem_a=%h want=00003011", mem_a); end
            end
            if (j == 4) begin
                total++;
                if (mem_a !== 32'h1000) begin bad++; $display("FAIL b2b_refill_start got mem_a=%h want=00001000", mem_a); end
            end
            if (got < 0 && return_config === 1'b1) got = j;
            else if (return_config !== 1'b0) pulse_bad++;
            if (got >= 0 && j >= got + 2) break;
        end
        if (got < 0) missing_config = 1'b0;
        total++; if (st_bad != 0) begin bad++; $display("FAIL b2b_store_cycles wrong=%0d want 0", st_bad); end
        total++; if (got != 69) begin bad++; $display("FAIL b2b_refill_done got edge=%0d want=69", got); end
        total++; if (pulse_bad != 0) begin bad++; $display("FAIL b2b_pulse wrong cycles=%0d want 0", pulse_bad); end
        total++; if (return_row !== exp_row) begin bad++; $display("FAIL b2b_row got=%h want=%h", return_row, exp_row); end
        total++; if ({ram[16'h3010], ram[16'h3011]} !== 16'hEFBE) begin bad++; $display("FAIL b2b_ram got=%h want=efbe", {ram[16'h3010], ram[16'h3011]}); end
    endtask

    task automatic test_rollback();
        int done_bad, a_bad;
        done_bad = 0; a_bad = 0;
        @(posedge clk); #1;
        lsb_addr = 32'h2000; lsb_size = 2'd2; lsb_we = 1'b0; lsb_req = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        rollback_config = 1'b1; lsb_req = 1'b0;
        @(posedge clk); #1;
        rollback_config = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (lsb_done !== 1'b0) done_bad++;
            if (mem_a !== 32'h2001) a_bad++;
            @(posedge clk);
        end
        total++; if (done_bad != 0) begin bad++; $display("FAIL rb_no_done pulses=%0d want 0", done_bad); end
        total++; if (a_bad != 0) begin bad++; $display("FAIL rb_addr_held wrong cycles=%0d want 0", a_bad); end
        #1;
        lsb_addr = 32'h2003; lsb_size = 2'd0; lsb_we = 1'b0; lsb_req = 1'b1; rollback_config = 1'b1;
        @(posedge clk); #1;
        rollback_config = 1'b0;
        @(negedge clk);
        total++; if (mem_a !== 32'h2001) begin bad++; $display("FAIL rb_idle_block got mem_a=%h want=00002001", mem_a); end
        done_bad = 0;
        for (int j = 0; j <= 3; j++) begin
            @(posedge clk);
            if (j == 3) begin #1; lsb_req = 1'b0; end
            @(negedge clk);
            if (lsb_done !== (j == 2)) done_bad++;
            if (j == 2) begin
                total++;
                if (lsb_rdata !== 32'h0000_0012) begin bad++; $display("FAIL rb_late_load got=%h want=00000012", lsb_rdata); end
            end
        end
        total++; if (done_bad != 0) begin bad++; $display("FAIL rb_late_done wrong cycles=%0d want 0", done_bad); end
    endtask

    task automatic test_stall_refill();
        logic [511:0] exp_row;
        int got, a_bad, pulse_bad, eff;
        got = -1; a_bad = 0; pulse_bad = 0;
        for (int k = 0; k < 64; k++) exp_row[8*k +: 8] = 8'(k) ^ 8'h5A;
        @(posedge clk); #1;
        missing_PC = 32'h0000_107F; missing_config = 1'b1;
        for (int j = 0; j <= 100; j++) begin
            @(posedge clk);
            if (j == 10) begin #1; rdy = 1'b0; end
            if (j == 15) begin #1; rdy = 1'b1; end
            if (j == 30) begin #1; rollback_config = 1'b1; end
            if (j == 31) begin #1; rollback_config = 1'b0; end
            if (got >= 0 && j == got + 1) begin #1; missing_config = 1'b0; end
            @(negedge clk);
            eff = (j <= 10) ? j : ((j <= 15) ? 10 : j - 5);
            if (eff < 64 && mem_a !== 32'h1040 + 32'(eff)) a_bad++;
            if (mem_wr !== 1'b0) a_bad++;
            if (got < 0 && return_config === 1'b1) got = j;
            else if (return_config !== 1'b0) pulse_bad++;
            if (got >= 0 && j >= got + 2) break;
        end
        if (got < 0) missing_config = 1'b0;
        total++; if (a_bad != 0) begin bad++; $display("FAIL stall_addr wrong cycles=%0d want 0", a_bad); end
        total++; if (got != 70) begin bad++; $display("FAIL stall_done got edge=%0d want=70", got); end
        total++; if (pulse_bad != 0) begin bad++; $display("FAIL stall_pulse wrong cycles=%0d want 0", pulse_bad); end
        total++; if (return_row !== exp_row) begin bad++; $display("FAIL stall_row got=%h want=%h", return_row, exp_row); end
    endtask

    task automatic test_async_reset();
        int done_bad;
        done_bad = 0;
        @(posedge clk); #1;
        lsb_addr = 32'h3020; lsb_size = 2'd2; lsb_we = 1'b1; lsb_wdata = 32'hCAFE_BABE; lsb_req = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        total++; if (mem_wr !== 1'b1 || mem_a !== 32'h3021) begin bad++; $display("FAIL rst_pre mem_wr=%b mem_a=%h want 1/00003021", mem_wr, mem_a); end
        #1; rst = 1'b1; lsb_req = 1'b0;
        #1;
        total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL rst_mem_wr got=%b want=0", mem_wr); end
        total++; if (mem_a !== 32'h0 || mem_dout !== 8'h0) begin bad++; $display("FAIL rst_bus mem_a=%h mem_dout=%h want 0/0", mem_a, mem_dout); end
        total++; if (lsb_rdata !== 32'h0 || return_row !== 512'h0) begin bad++; $display("FAIL rst_data rdata=%h row nonzero=%b want 0", lsb_rdata, |return_row); end
        total++; if ({return_config, lsb_done} !== 2'b00) begin bad++; $display("FAIL rst_pulses got=%b want=00", {return_config, lsb_done}); end
        @(negedge clk);
        rst = 1'b0;
        total++; if ({ram[16'h3020], ram[16'h3021]} !== 16'hBE00) begin bad++; $display("FAIL rst_ram got=%h want=be00", {ram[16'h3020], ram[16'h3021]}); end
        @(posedge clk); #1;
        lsb_addr = 32'h3020; lsb_size = 2'd0; lsb_we = 1'b0; lsb_req = 1'b1;
        for (int j = 0; j <= 3; j++) begin
            @(posedge clk);
            if (j == 3) begin #1; lsb_req = 1'b0; end
            @(negedge clk);
            if (lsb_done !== (j == 2)) done_bad++;
            if (j == 2) begin
                total++;
                if (lsb_rdata !== 32'h0000_00BE) begin bad++; $display("FAIL rst_after_load got=%h want=000000be", lsb_rdata); end
            end
        end
        total++; if (done_bad != 0) begin bad++; $display("FAIL rst_after_done wrong cycles=%0d want 0", done_bad); end
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1;
        missing_PC = 32'h0; missing_config = 1'b0;
        lsb_req = 1'b0; lsb_we = 1'b0; lsb_size = 2'd0; lsb_addr = 32'h0; lsb_wdata = 32'h0;
        rollback_config = 1'b0;
        for (int i = 0; i < 65536; i++) ram[i] <= 8'h00;
        for (int k = 0; k < 64; k++) begin
            ram[16'h1000 + 16'(k)] <= 8'(k);
            ram[16'h1040 + 16'(k)] <= 8'(k) ^ 8'h5A;
        end
        ram[16'h2000] <= 8'h78; ram[16'h2001] <= 8'h56;
        ram[16'h2002] <= 8'h34; ram[16'h2003] <= 8'h12;
        ram[16'h3000] <= 8'h11; ram[16'h3001] <= 8'h22; ram[16'h3002] <= 8'h33;
        repeat (2) @(posedge clk);

        test_reset();
        test_refill();
        test_load();
        test_store();
        test_back_to_back();
        test_rollback();
        test_stall_refill();
        test_async_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller bridging the core's refill and load/store clients to the single byte-wide RAM port. Services instruction-cache line refills issued by `ifetch` (missing_PC/missing_config → return_row/return_config) and byte/half/word accesses from the load-store buffer. Serializes all traffic onto one 8-bit RAM bus with fixed priority and one-cycle request guards.

## Interface
Parameters:
- LINE_BYTES, 64, bytes per I-cache line (return_row width = 8*LINE_BYTES)
- ADDR_W, 32, address width

Ports:
- clk  in  1  clock; all state updates on posedge clk
- rst  in  1  reset, asynchronous, active-high
- rdy  in  1  global enable; 0 freezes all registers
- missing_PC  in  32  miss address from ifetch; line base = missing_PC[31:6]
- missing_config  in  1  refill request, level, held until return_config seen
- return_row  out  512  refilled line; byte k at [8k+7:8k]
- return_config  out  1  one-cycle pulse, return_row valid
- lsb_req  in  1  load/store request, level, held until lsb_done
- lsb_we  in  1  1 = store, 0 = load
- lsb_size  in  2  0 byte, 1 half, 2 word (3 illegal, treated as word)
- lsb_addr  in  32  byte address
- lsb_wdata  in  32  store data, little-endian
- lsb_rdata  out  32  load data, zero-extended (sign handled by LSB)
- lsb_done  out  1  one-cycle completion pulse
- rollback_config  in  1  ROB flush
- mem_din  in  8  RAM read data, valid one cycle after address
- mem_dout  out  8  RAM write data
- mem_a  out  32  RAM address
- mem_wr  out  1  1 = write; forced 0 whenever rdy=0

## Operation
- States: IDLE, IF_READ, LS_READ, LS_WRITE, DONE. Byte counter cnt (7 bits).
- IDLE arbitration, priority: lsb_req (store or load) over missing_config. Request accepted at the edge it is sampled.
- IF_READ: issue mem_a = base+0..base+63, one per cycle; capture mem_din into return_row byte (cnt-1). After byte 63 captured, pulse return_config, go DONE.
- LS_READ: issue n = 1/2/4 addresses lsb_addr+0..n-1; capture bytes into lsb_rdata[8i+7:8i], upper bytes 0; pulse lsb_done, go DONE.
- LS_WRITE: drive mem_wr=1, mem_a=lsb_addr+i, mem_dout=lsb_wdata[8i+7:8i] for i=0..n-1; then pulse lsb_done, go DONE.
- DONE: one cycle, ignores all requests (client drops its level one edge after seeing the pulse), then IDLE.
- Rollback: in LS_READ → abort to IDLE, no lsb_done, mem_a unchanged. LS_WRITE and IF_READ ignore rollback (stores are committed; ifetch still waits for its refill). Rollback in IDLE blocks acceptance of a load that cycle; stores still accepted.
- rdy=0: state, cnt, outputs held; resumes exactly where stopped.
- Reset (any time, incl. mid-refill): state IDLE, cnt 0, mem_a 0, mem_dout 0, mem_wr 0, return_row 0, return_config 0, lsb_rdata 0, lsb_done 0.
- Address arithmetic mod 2^32; line base never crosses (bits [5:0] forced 0).

## Timing
- Acceptance edge E0. Address byte k on mem_a during cycle after E(k); data captured at E(k+2).
- Refill: return_config high during cycle after E65; DONE after E66; IDLE accepts again at E67.
- Load n bytes: lsb_done high after E(n+1). Store n bytes: mem_wr high cycles 1..n, lsb_done high after E(n).
- Exactly one outstanding access; pulses never longer than one cycle.

## Structure
- Shared package: state encoding, size codes (SZ_B/SZ_H/SZ_W), LINE_BYTES, size→byte-count function.
- Single module; no sub-module needed.

## Test plan
- Refill: RAM[0x1000+k]=k, missing_PC=0x1004 → return_config at E65, return_row byte k = k, 64 reads 0x1000..0x103F.
- Load word 0x2000 holding 78 56 34 12 → lsb_rdata=0x12345678, lsb_done after E5; half at 0x2002 → 0x00001234.
- Store byte 0xAB to 0x3001 → single mem_wr cycle, mem_a=0x3001, mem_dout=0xAB, neighbours untouched.
- Simultaneous lsb_req (store) and missing_config → store first, refill starts at E(n+2); no request re-accepted in DONE.
- Rollback during LS_READ cnt=1 → no lsb_done, IDLE next edge; rollback during refill → refill completes normally.
- rdy low 5 cycles mid-refill and async rst mid-store → row unchanged/correct; after reset all outputs 0, mem_wr 0 immediately.
